// File: rtl/cpu_pkg.sv
// Shared types and constants for the divide accelerator.
// No logic: state encoding and default operand width only.
// No flow control: pure declarations.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } t_div_state;

  localparam int DIV_WIDTH = 16;

endpackage

// File: rtl/div_step.sv
// One restoring-divide step: shift in the next dividend bit, trial-subtract.
// Latency: purely combinational, chained STEPS_PER_CYCLE deep by the controller.
// No flow control: always evaluates its inputs.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   pr_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   pr_out,
  output logic [WIDTH-1:0] q_out
);

  // The top PR bit is always shifted out; it only exists so the compare is WIDTH+1 wide.
  logic             unused_pr_msb;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   dext;
  logic             qbit;

  assign unused_pr_msb = pr_in[WIDTH];
  assign trial         = {pr_in[WIDTH-1:0], q_in[WIDTH-1]};
  assign dext          = {1'b0, d};

  // Restore-or-subtract decision for this bit position.
  always_comb begin
    qbit   = 1'b0;
    pr_out = trial;
    if (trial >= dext) begin
      qbit   = 1'b1;
      pr_out = trial - dext;
    end
  end

  assign q_out = {q_in[WIDTH-2:0], qbit};

endmodule

// File: rtl/div_controller.sv
// Iterative unsigned restoring divider: start/abort in, quotient/remainder + one-cycle Done out.
// Latency: Done at T + WIDTH/STEPS_PER_CYCLE + 1 after an accepted start; T+1 for a zero divisor.
// Backpressure: none; StartDiv is ignored while Busy, and Abort cancels a run without a Done.
module div_controller
  import cpu_pkg::*;
#(
  parameter int WIDTH           = DIV_WIDTH,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             StartDiv,
  input  logic [WIDTH-1:0] Divident,
  input  logic [WIDTH-1:0] Divisor,
  input  logic             Abort,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero
);

  localparam int NCYC = WIDTH / STEPS_PER_CYCLE;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(NCYC - 1);

  t_div_state       state;
  logic [WIDTH-1:0] dreg;
  logic [WIDTH-1:0] qreg;
  logic [WIDTH:0]   pr;
  logic [CW-1:0]    cnt;

  // Step chain: element 0 is the registered value, element STEPS_PER_CYCLE is this cycle's result.
  logic [WIDTH:0]   pr_chain [STEPS_PER_CYCLE+1];
  logic [WIDTH-1:0] q_chain  [STEPS_PER_CYCLE+1];

  assign pr_chain[0] = pr;
  assign q_chain[0]  = qreg;

  genvar g;
  generate
    for (g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
      div_step #(.WIDTH(WIDTH)) u_step (
        .pr_in  (pr_chain[g]),
        .q_in   (q_chain[g]),
        .d      (dreg),
        .pr_out (pr_chain[g+1]),
        .q_out  (q_chain[g+1])
      );
    end
  endgenerate

  // Status flags come straight off the state register so they cannot glitch.
  assign Busy = (state == S_RUN);
  assign Done = (state == S_DONE);

  // Sequencer: start acceptance, iteration counting, abort and result capture.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= S_IDLE;
      dreg      <= '0;
      qreg      <= '0;
      pr        <= '0;
      cnt       <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (Abort) begin
            // Results from the previous completion are left untouched.
            state <= S_IDLE;
          end else begin
            qreg <= q_chain[STEPS_PER_CYCLE];
            pr   <= pr_chain[STEPS_PER_CYCLE];
            if (cnt == '0) begin
              Quotient  <= q_chain[STEPS_PER_CYCLE];
              Remainder <= pr_chain[STEPS_PER_CYCLE][WIDTH-1:0];
              DivByZero <= 1'b0;
              state     <= S_DONE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        default: begin
          // S_IDLE and S_DONE both accept; Abort suppresses acceptance.
          if (StartDiv && !Abort) begin
            dreg <= Divisor;
            qreg <= Divident;
            pr   <= '0;
            cnt  <= CNT_LOAD;
            if (Divisor == '0) begin
              Quotient  <= '1;
              Remainder <= Divident;
              DivByZero <= 1'b1;
              state     <= S_DONE;
            end else begin
              state <= S_RUN;
            end
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_controller.sv
// Self-checking bench: two divider instances (1 and 4 steps per cycle) against an arithmetic model.
// Latency: checked per operation against the documented cycle counts.
// Backpressure: exercises ignored starts, back-to-back starts, abort and mid-run reset.
module tb_div_controller;

  logic        clk;
  logic        rst   [2];
  logic        start [2];
  logic        abort [2];
  logic [15:0] dvd   [2];
  logic [15:0] dvs   [2];
  logic        busy  [2];
  logic        done  [2];
  logic [15:0] quo   [2];
  logic [15:0] rem   [2];
  logic        dz    [2];

  int errors = 0;
  int checks = 0;

  div_controller #(.WIDTH(16), .STEPS_PER_CYCLE(1)) u_dut1 (
    .Clk(clk), .Reset(rst[0]), .StartDiv(start[0]), .Divident(dvd[0]), .Divisor(dvs[0]),
    .Abort(abort[0]), .Busy(busy[0]), .Done(done[0]), .Quotient(quo[0]),
    .Remainder(rem[0]), .DivByZero(dz[0])
  );

  div_controller #(.WIDTH(16), .STEPS_PER_CYCLE(4)) u_dut4 (
    .Clk(clk), .Reset(rst[1]), .StartDiv(start[1]), .Divident(dvd[1]), .Divisor(dvs[1]),
    .Abort(abort[1]), .Busy(busy[1]), .Done(done[1]), .Quotient(quo[1]),
    .Remainder(rem[1]), .DivByZero(dz[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int run_cycles(input int k);
    return (k == 0) ? 16 : 4;
  endfunction

  // Issue a start in the current cycle and check latency, busy span and results.
  task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b, input string tag);
    int cyc;
    int nbusy;
    logic [15:0] eq;
    logic [15:0] er;
    logic        edz;
    int          elat;
    if (b == 16'd0) begin
      eq = 16'hFFFF; er = a; edz = 1'b1; elat = 1;
    end else begin
      eq = a / b; er = a % b; edz = 1'b0; elat = run_cycles(k) + 1;
    end
    start[k] = 1'b1; dvd[k] = a; dvs[k] = b;
    tick();
    start[k] = 1'b0;
    dvd[k]   = 16'($urandom);
    dvs[k]   = 16'($urandom);
    cyc   = 1;
    nbusy = 0;
    while (!done[k] && cyc < 64) begin
      if (busy[k]) nbusy++;
      tick();
      cyc++;
    end
    chk({tag, "_lat"},  cyc,   elat);
    chk({tag, "_busy"}, nbusy, elat - 1);
    chk({tag, "_q"},    quo[k], eq);
    chk({tag, "_r"},    rem[k], er);
    chk({tag, "_dz"},   dz[k],  edz);
  endtask

  // One quiet cycle after a Done: the pulse must have dropped.
  task automatic idle_cycle(input int k, input string tag);
    tick();
    chk({tag, "_done_drop"}, done[k], 1'b0);
    chk({tag, "_busy_idle"}, busy[k], 1'b0);
  endtask

  initial begin
    int nd;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; start[k] = 1'b0; abort[k] = 1'b0; dvd[k] = '0; dvs[k] = '0;
    end
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", busy[k], 1'b0);
      chk("rst_done", done[k], 1'b0);
      chk("rst_q",    quo[k],  16'd0);
      chk("rst_r",    rem[k],  16'd0);
      chk("rst_dz",   dz[k],   1'b0);
      rst[k] = 1'b0;
    end
    tick();

    // Basic division and zero-divisor handling.
    run_op(0, 16'd20000, 16'd10, "d20000_10");
    idle_cycle(0, "d20000_10");
    run_op(0, 16'd7, 16'd0, "div0");
    idle_cycle(0, "div0");
    run_op(0, 16'd3, 16'd7, "d3_7");
    idle_cycle(0, "d3_7");

    // Back-to-back: second start issued in the Done cycle of the first.
    run_op(0, 16'hFFFF, 16'd1, "ffff_1");
    run_op(0, 16'hFFFF, 16'hFFFF, "ffff_ffff");
    idle_cycle(0, "ffff_ffff");

    // A start during RUN is dropped, not queued.
    start[0] = 1'b1; dvd[0] = 16'd1000; dvs[0] = 16'd3;
    tick();
    start[0] = 1'b0;
    repeat (3) tick();
    start[0] = 1'b1; dvd[0] = 16'd50; dvs[0] = 16'd5;
    tick();
    start[0] = 1'b0;
    nd = 5;
    while (!done[0] && nd < 64) begin tick(); nd++; end
    chk("ign_lat", nd, 17);
    chk("ign_q", quo[0], 16'd333);
    chk("ign_r", rem[0], 16'd1);
    idle_cycle(0, "ign");
    tick();
    chk("ign_no_second_run", busy[0], 1'b0);

    // Abort mid-run keeps the previous result and suppresses Done.
    run_op(0, 16'd100, 16'd7, "d100_7");
    idle_cycle(0, "d100_7");
    start[0] = 1'b1; dvd[0] = 16'd500; dvs[0] = 16'd9;
    tick();
    start[0] = 1'b0;
    repeat (5) tick();
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    chk("abort_busy", busy[0], 1'b0);
    chk("abort_done", done[0], 1'b0);
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      if (done[0]) nd++;
      tick();
    end
    chk("abort_no_done", nd, 0);
    chk("abort_q", quo[0], 16'd14);
    chk("abort_r", rem[0], 16'd2);
    chk("abort_dz", dz[0], 1'b0);

    // Abort wins over a simultaneous start.
    start[0] = 1'b1; abort[0] = 1'b1; dvd[0] = 16'd9; dvs[0] = 16'd2;
    tick();
    start[0] = 1'b0; abort[0] = 1'b0;
    chk("abort_start_busy", busy[0], 1'b0);
    chk("abort_start_done", done[0], 1'b0);

    // Reset in the middle of a run clears everything.
    start[0] = 1'b1; dvd[0] = 16'd40000; dvs[0] = 16'd3;
    tick();
    start[0] = 1'b0;
    repeat (4) tick();
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    chk("mrst_busy", busy[0], 1'b0);
    chk("mrst_done", done[0], 1'b0);
    chk("mrst_q",    quo[0],  16'd0);
    chk("mrst_r",    rem[0],  16'd0);
    chk("mrst_dz",   dz[0],   1'b0);

    // Four steps per cycle.
    run_op(1, 16'd20000, 16'd10, "s4_20000_10");
    idle_cycle(1, "s4_20000_10");

    // Random sweep on both instances, mixing idle gaps and back-to-back starts.
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 40; n++) begin
        logic [15:0] a;
        logic [15:0] b;
        a = 16'($urandom);
        case ($urandom_range(0, 7))
          0:       b = 16'd0;
          1:       b = 16'hFFFF - 16'($urandom_range(0, 3));
          2, 3:    b = 16'($urandom_range(1, 15));
          default: b = 16'($urandom);
        endcase
        run_op(k, a, b, "rnd");
        if ($urandom_range(0, 1) == 0) idle_cycle(k, "rnd");
      end
      idle_cycle(k, "rnd_end");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
